// File: rtl/divider.sv
// Sequential unsigned divider: radix-2 restoring shift-subtract, one quotient bit per clock.
// Operands are latched on start; quo/r update only on completion and hold until the next one.
module divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH:0]   shifted;
  logic             qbit;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] dvd_n;

  // Compare on WIDTH+1 bits; the subtraction only needs WIDTH bits because
  // whenever it is taken the true difference is below the divisor.
  always_comb begin
    shifted = {rem, dvd[WIDTH-1]};
    qbit    = (shifted >= {1'b0, dvs});
    rem_n   = qbit ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
    dvd_n   = {dvd[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      quo   <= '0;
      r     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd   <= a;
            dvs   <= div;
            rem   <= '0;
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          rem <= rem_n;
          dvd <= dvd_n;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            quo   <= dvd_n;
            r     <= rem_n;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes expected {quo, r, done cycle},
// an independent monitor pops and compares on every done pulse.
module tb_divider;
  localparam int W = 64;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] div = '0;
  logic [W-1:0] quo, r;
  logic         busy, done;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] rm;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [W-1:0] last_q = '0;

  divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .div(div),
    .quo(quo), .r(r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("quo", quo, e.q);
        check("rem", r, e.rm);
        check("done_cycle", W'(cyc), W'(e.cyc));
        check("busy_at_done", W'(busy), W'(0));
        last_q = e.q;
      end
    end
  end

  // Drive start for one edge from a negedge; the sampled edge is cyc+1, done seen at cyc+1+W.
  task automatic pulse(input logic [W-1:0] av, input logic [W-1:0] dv, input bit expect_it,
                       input logic [W-1:0] eq, input logic [W-1:0] er);
    exp_t e;
    a = av; div = dv; start = 1'b1;
    if (expect_it) begin
      e.q = eq; e.rm = er; e.cyc = cyc + 1 + W;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++; errors++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] dv,
                       input logic [W-1:0] eq, input logic [W-1:0] er);
    wait_idle();
    pulse(av, dv, 1'b1, eq, er);
  endtask

  task automatic wait_done_cycle();
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_done: done not seen within %0d cycles", n);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rd;
    repeat (3) @(negedge clk);
    check("reset_quo", quo, '0);
    check("reset_rem", r, '0);
    check("reset_busy", W'(busy), W'(0));
    check("reset_done", W'(done), W'(0));
    rst = 1'b0;
    @(negedge clk);

    // Basic, large/small, boundaries
    issue(64'd8, 64'd2, 64'd4, 64'd0);
    issue(64'd9, 64'd2, 64'd4, 64'd1);
    issue(64'd42398284, 64'd54389, 64'd779, 64'd29253);
    issue(64'd34224, 64'd789799, 64'd0, 64'd34224);
    issue(ONES, 64'd1, ONES, 64'd0);
    issue(ONES, ONES, 64'd1, 64'd0);
    issue(64'd5, 64'd0, ONES, 64'd5);
    issue(64'd0, 64'd7, 64'd0, 64'd0);
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 64'd0, 64'h8000_0000_0000_0000);
    issue(ONES, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF);
    drain();

    // Start during RUN is ignored; quo holds the previous result mid-run
    issue(64'd100, 64'd7, 64'd14, 64'd2);
    repeat (10) @(negedge clk);
    pulse(64'd1000, 64'd3, 1'b0, '0, '0);
    a = 64'd12345; div = 64'd1;
    repeat (5) @(negedge clk);
    check("busy_in_run", W'(busy), W'(1));
    check("quo_hold_in_run", quo, last_q);
    drain();

    // Back-to-back: start in the done cycle
    issue(64'd1000, 64'd10, 64'd100, 64'd0);
    wait_done_cycle();
    pulse(64'd1001, 64'd10, 1'b1, 64'd100, 64'd1);
    drain();

    // Async reset mid-run clears outputs without a clock edge
    issue(64'd77, 64'd5, 64'd15, 64'd2);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_quo", quo, '0);
    check("rst_rem", r, '0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(64'd77, 64'd5, 64'd15, 64'd2);
    drain();

    // Random pairs against the arithmetic reference
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom(), $urandom()};
      rd = {$urandom(), $urandom()};
      if (i % 4 == 1) rd = rd >> $urandom_range(60, 1);
      if (rd == 0) rd = 64'd3;
      issue(ra, rd, ra / rd, ra % rd);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
